// File: rtl/plot_scheduler.sv
// Plot-port scheduler for the 160x120 VGA adapter: arbitrates user/simulation cell
// requests and a full-screen clear, expanding each cell into single-pixel plots.
module plot_scheduler #(
   parameter int GRID_W  = 40,
   parameter int GRID_H  = 30,
   parameter int CELL_PX = 4,
   parameter int SCR_W   = 160,
   parameter int SCR_H   = 120
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clear_req,
   input  logic       usr_valid,
   output logic       usr_ready,
   input  logic [5:0] usr_cx,
   input  logic [4:0] usr_cy,
   input  logic [2:0] usr_colour,
   input  logic       sim_valid,
   output logic       sim_ready,
   input  logic [5:0] sim_cx,
   input  logic [4:0] sim_cy,
   input  logic [2:0] sim_colour,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       clear_done,
   output logic       range_err
);

   typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

   localparam logic [5:0] GW_LIM  = 6'(GRID_W);
   localparam logic [4:0] GH_LIM  = 5'(GRID_H);
   localparam logic [7:0] CELL_X  = 8'(CELL_PX);
   localparam logic [6:0] CELL_Y  = 7'(CELL_PX);
   localparam logic [7:0] PX_LAST = 8'(CELL_PX - 1);
   localparam logic [6:0] PY_LAST = 7'(CELL_PX - 1);
   localparam logic [7:0] X_LAST  = 8'(SCR_W - 1);
   localparam logic [6:0] Y_LAST  = 7'(SCR_H - 1);

   state_t     state, state_nx;
   logic       clear_pending, pend_nx;
   logic       rr_usr, rr_nx;
   logic [7:0] base_x, bx_nx, px, px_nx, x_nx;
   logic [6:0] base_y, by_nx, py, py_nx, y_nx;
   logic [2:0] colour_nx;
   logic       plot_nx, done_nx, err_nx;
   logic       grant_usr, grant_sim;
   logic [5:0] sel_cx;
   logic [4:0] sel_cy;
   logic [2:0] sel_col;

   always_comb begin
      state_nx  = state;
      pend_nx   = clear_pending | clear_req;
      rr_nx     = rr_usr;
      bx_nx     = base_x;
      by_nx     = base_y;
      px_nx     = px;
      py_nx     = py;
      x_nx      = x;
      y_nx      = y;
      colour_nx = colour;
      plot_nx   = 1'b0;
      done_nx   = 1'b0;
      err_nx    = 1'b0;
      usr_ready = 1'b0;
      sim_ready = 1'b0;
      // rr_usr set means usr wins a tie
      grant_usr = usr_valid & (~sim_valid | rr_usr);
      grant_sim = sim_valid & ~grant_usr;
      sel_cx    = grant_usr ? usr_cx     : sim_cx;
      sel_cy    = grant_usr ? usr_cy     : sim_cy;
      sel_col   = grant_usr ? usr_colour : sim_colour;

      case (state)
         IDLE: begin
            if (clear_pending) begin
               state_nx  = CLEAR;
               pend_nx   = clear_req;
               x_nx      = '0;
               y_nx      = '0;
               colour_nx = '0;
               plot_nx   = 1'b1;
            end else if (grant_usr || grant_sim) begin
               usr_ready = grant_usr;
               sim_ready = grant_sim;
               rr_nx     = grant_sim;
               if (sel_cx < GW_LIM && sel_cy < GH_LIM) begin
                  state_nx  = PAINT;
                  bx_nx     = 8'(sel_cx) * CELL_X;
                  by_nx     = 7'(sel_cy) * CELL_Y;
                  px_nx     = '0;
                  py_nx     = '0;
                  x_nx      = bx_nx;
                  y_nx      = by_nx;
                  colour_nx = sel_col;
                  plot_nx   = 1'b1;
               end else begin
                  err_nx = 1'b1;
               end
            end
         end
         PAINT: begin
            if (px == PX_LAST && py == PY_LAST) begin
               state_nx = IDLE;
            end else begin
               if (px == PX_LAST) begin
                  px_nx = '0;
                  py_nx = py + 7'd1;
               end else begin
                  px_nx = px + 8'd1;
               end
               x_nx    = base_x + px_nx;
               y_nx    = base_y + py_nx;
               plot_nx = 1'b1;
            end
         end
         CLEAR: begin
            if (x == X_LAST && y == Y_LAST) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else begin
               if (x == X_LAST) begin
                  x_nx = '0;
                  y_nx = y + 7'd1;
               end else begin
                  x_nx = x + 8'd1;
               end
               plot_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= IDLE;
         clear_pending <= 1'b0;
         rr_usr        <= 1'b1;
         base_x        <= '0;
         base_y        <= '0;
         px            <= '0;
         py            <= '0;
         x             <= '0;
         y             <= '0;
         colour        <= '0;
         plot          <= 1'b0;
         busy          <= 1'b0;
         clear_done    <= 1'b0;
         range_err     <= 1'b0;
      end else begin
         state         <= state_nx;
         clear_pending <= pend_nx;
         rr_usr        <= rr_nx;
         base_x        <= bx_nx;
         base_y        <= by_nx;
         px            <= px_nx;
         py            <= py_nx;
         x             <= x_nx;
         y             <= y_nx;
         colour        <= colour_nx;
         plot          <= plot_nx;
         busy          <= (state_nx != IDLE);
         clear_done    <= done_nx;
         range_err     <= err_nx;
      end
   end

endmodule
